// File: rtl/sbqm_pkg.sv
// Types and constants shared by the bank-queue service side and the entry/exit counter.
package sbqm_pkg;

    localparam int COUNT_W_DEF  = 3;
    localparam int TELLER_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        CALL,
        RELEASE,
        GAP
    } sbqm_state_e;

endpackage

// File: rtl/sbqm_rr_pick.sv
// Round-robin selector: finds the first set bit of avail at or after ptr, wrapping modulo N_TELLERS.
module sbqm_rr_pick
    import sbqm_pkg::*;
#(
    parameter int N_TELLERS = 3
) (
    input  logic [N_TELLERS-1:0]    avail,
    input  logic [TELLER_IDX_W-1:0] ptr,
    output logic                    found,
    output logic [TELLER_IDX_W-1:0] idx
);

    always_comb begin
        int k;
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = 0; i < N_TELLERS; i++) begin
            k = int'(ptr) + i;
            if (k >= N_TELLERS) begin
                k = k - N_TELLERS;
            end
            if (!found && avail[k]) begin
                found = 1'b1;
                idx   = TELLER_IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/sbqm_teller_dispatch.sv
// Teller dispatch: calls queued customers to free staffed tellers round-robin and strobes
// the exit gate once each customer is seated or dropped as a no-show.
module sbqm_teller_dispatch
    import sbqm_pkg::*;
#(
    parameter int N_TELLERS    = 3,
    parameter int COUNT_W      = COUNT_W_DEF,
    parameter int CALL_TIMEOUT = 20,
    parameter int MAX_RECALL   = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int SVC_UNITS    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COUNT_W-1:0]      p_count,
    input  logic                    eflag,
    input  logic [N_TELLERS-1:0]    teller_open,
    input  logic [N_TELLERS-1:0]    teller_start,
    input  logic [N_TELLERS-1:0]    teller_done,
    output logic                    call_valid,
    output logic [TELLER_IDX_W-1:0] call_teller,
    output logic                    leave_n,
    output logic                    noshow,
    output logic [N_TELLERS-1:0]    busy,
    output logic [COUNT_W+7:0]      wait_est
);

    localparam int WAIT_W   = COUNT_W + 8;
    localparam int PROD_W   = COUNT_W + 32;
    localparam int TIMER_W  = $clog2(CALL_TIMEOUT + 1);
    localparam int RECALL_W = $clog2(MAX_RECALL + 2);
    localparam int GAP_W    = $clog2(GAP_CYCLES + 2);

    localparam logic [TIMER_W-1:0]      TIMER_LAST = TIMER_W'(CALL_TIMEOUT - 1);
    localparam logic [RECALL_W-1:0]     RECALL_MAX = RECALL_W'(MAX_RECALL);
    localparam logic [GAP_W-1:0]        GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TELLER_IDX_W-1:0] LAST_IDX   = TELLER_IDX_W'(N_TELLERS - 1);

    sbqm_state_e               state_q, state_d;
    logic                      call_valid_q, call_valid_d;
    logic [TELLER_IDX_W-1:0]   call_teller_q, call_teller_d;
    logic                      leave_n_q, leave_n_d;
    logic                      noshow_q, noshow_d;
    logic [N_TELLERS-1:0]      busy_q, busy_d;
    logic [WAIT_W-1:0]         wait_est_q, wait_est_d;
    logic [TELLER_IDX_W-1:0]   rr_q, rr_d;
    logic [RECALL_W-1:0]       recall_q, recall_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [GAP_W-1:0]          gap_q, gap_d;

    logic [N_TELLERS-1:0]      avail;
    logic                      pick_found;
    logic [TELLER_IDX_W-1:0]   pick_idx;
    logic                      dispatch_ok;
    logic                      start_hit;
    logic                      open_hit;
    logic                      timeout;
    logic [PROD_W-1:0]         prod;

    assign avail = teller_open & ~busy_q;

    sbqm_rr_pick #(
        .N_TELLERS (N_TELLERS)
    ) u_pick (
        .avail (avail),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign dispatch_ok = !eflag && (p_count != '0) && pick_found;
    assign start_hit   = teller_start[call_teller_q];
    assign open_hit    = teller_open[call_teller_q];
    assign timeout     = (timer_q == TIMER_LAST);

    // Start on the called teller outranks a coincident timeout or window closure.
    always_comb begin
        state_d       = state_q;
        call_valid_d  = call_valid_q;
        call_teller_d = call_teller_q;
        noshow_d      = 1'b0;
        busy_d        = busy_q & ~teller_done;
        rr_d          = rr_q;
        recall_d      = recall_q;
        timer_d       = timer_q;
        gap_d         = gap_q;

        case (state_q)
            IDLE: begin
                if (dispatch_ok) begin
                    call_teller_d = pick_idx;
                    call_valid_d  = 1'b1;
                    timer_d       = '0;
                    recall_d      = '0;
                    state_d       = CALL;
                end
            end
            CALL: begin
                timer_d = timer_q + TIMER_W'(1);
                if (start_hit) begin
                    busy_d[call_teller_q] = 1'b1;
                    call_valid_d          = 1'b0;
                    rr_d    = (call_teller_q == LAST_IDX) ? '0 : call_teller_q + TELLER_IDX_W'(1);
                    state_d = RELEASE;
                end else if (!open_hit) begin
                    call_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (timeout) begin
                    if (recall_q < RECALL_MAX) begin
                        recall_d = recall_q + RECALL_W'(1);
                        timer_d  = '0;
                    end else begin
                        noshow_d     = 1'b1;
                        call_valid_d = 1'b0;
                        state_d      = RELEASE;
                    end
                end
            end
            RELEASE: begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        leave_n_d = (state_d != RELEASE);
    end

    always_comb begin
        prod       = PROD_W'(p_count) * PROD_W'(SVC_UNITS);
        wait_est_d = (|prod[PROD_W-1:WAIT_W]) ? '1 : prod[WAIT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            call_valid_q  <= 1'b0;
            call_teller_q <= '0;
            leave_n_q     <= 1'b1;
            noshow_q      <= 1'b0;
            busy_q        <= '0;
            wait_est_q    <= '0;
            rr_q          <= '0;
            recall_q      <= '0;
            timer_q       <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            call_valid_q  <= call_valid_d;
            call_teller_q <= call_teller_d;
            leave_n_q     <= leave_n_d;
            noshow_q      <= noshow_d;
            busy_q        <= busy_d;
            wait_est_q    <= wait_est_d;
            rr_q          <= rr_d;
            recall_q      <= recall_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
        end
    end

    assign call_valid  = call_valid_q;
    assign call_teller = call_teller_q;
    assign leave_n     = leave_n_q;
    assign noshow      = noshow_q;
    assign busy        = busy_q;
    assign wait_est    = wait_est_q;

endmodule

// File: doc/sbqm_teller_dispatch.md
Name: sbqm_teller_dispatch

Overview:
Service-side controller for the bank queue: it pulls customers out of the queue that the entry/exit queue counter tracks. It watches the counter's occupancy and empty flag and selects a free, staffed teller by round-robin. It announces the call, waits for the customer to be seated, and then emits the exit-gate strobe that decrements the counter. It also reports per-teller busy status and a simple wait-time estimate for the lobby display.

Parameters:
N_TELLERS, 3, number of teller windows (1..8)
COUNT_W, 3, width of queue occupancy from the counter
CALL_TIMEOUT, 20, cycles to wait for the customer to be seated before a re-call
MAX_RECALL, 2, re-calls before the customer is dropped as a no-show
GAP_CYCLES, 2, settle cycles after a strobe so the counter updates before the next decision
SVC_UNITS, 5, wait-time units charged per queued customer

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
p_count  in  COUNT_W  customers currently queued (from counter)
eflag  in  1  queue-empty flag (from counter)
teller_open  in  N_TELLERS  level; teller window is staffed
teller_start  in  N_TELLERS  1-cycle pulse; called customer seated at teller k
teller_done  in  N_TELLERS  1-cycle pulse; service at teller k finished
call_valid  out  1  a call is being announced
call_teller  out  3  index of the teller being called (valid while call_valid)
leave_n  out  1  exit-gate strobe to counter, active-low, exactly 1 cycle low per removal
noshow  out  1  1-cycle pulse when a customer is dropped after MAX_RECALL re-calls
busy  out  N_TELLERS  teller k is serving
wait_est  out  COUNT_W+8  p_count*SVC_UNITS, registered

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, call_valid=0, call_teller=0, leave_n=1, noshow=0, busy=0, wait_est=0, rr pointer=0, recall count=0, timer=0.
- avail[k] = teller_open[k] & ~busy[k]. A dispatch is possible when eflag=0, p_count!=0 and avail!=0.
- IDLE: if a dispatch is possible, pick the first avail teller at or after the rr pointer (modulo N_TELLERS). Latch it into call_teller, set call_valid=1, clear timer and recall count, go to CALL. call_valid rises one cycle after the condition is seen.
- CALL: timer increments each cycle.
  - teller_start[call_teller]=1: set busy[call_teller], drop call_valid, advance rr = call_teller+1 (wrap), go to RELEASE.
  - Else, if teller_open[call_teller] drops: abort. Drop call_valid, no strobe, go to IDLE.
  - Else, if timer reaches CALL_TIMEOUT-1 and recall count < MAX_RECALL: increment recall count, clear timer, keep call_valid=1 (re-announce).
  - Else, on timeout with recall count = MAX_RECALL: pulse noshow, drop call_valid, go to RELEASE (the no-show is removed from the queue).
  - If start and timeout occur in the same cycle, start wins.
  - teller_start on any other teller is ignored.
- RELEASE: leave_n=0 for exactly this one cycle, then go to GAP.
- GAP: hold leave_n=1 for GAP_CYCLES, then return to IDLE. No call is issued in GAP even if the condition holds.
- teller_done[k]: clears busy[k] in any state, including reset-free cycles.
  - done for a non-busy teller is ignored.
  - done and start on the same teller in the same cycle: busy=1 (start wins).
- Queue drains (eflag=1 or p_count=0) while in CALL: the call continues. Customers already called are honoured, and the counter guards the underflow.
- wait_est updates every cycle from p_count and saturates to all-ones (no wrap).
- Reset asserted mid-CALL or mid-RELEASE: outputs return to reset values at that edge, and leave_n is high in the cycle after.

Decomposition:
- Shared package sbqm_pkg holds the state enum (IDLE, CALL, RELEASE, GAP), teller index width, and COUNT_W default, shared with the counter.
- One sub-module is natural: sbqm_rr_pick, a combinational round-robin first-one-from-pointer selector over avail. It returns a found flag and an index.

Test Plan:
- Reset, p_count=3, eflag=0, teller_open=3'b111 -> call_valid=1 with call_teller=0 next cycle; teller_start[0] -> busy=001, leave_n low 1 cycle, then after GAP a call to teller 1.
- busy=3'b011 (tellers 0 and 1 serving), rr=0, p_count=2 -> call_teller=2; teller_done[0] then next dispatch -> call_teller=0 (wrap).
- Call teller 1 with no start for 3*CALL_TIMEOUT cycles (MAX_RECALL=2) -> call_valid stays high throughout; noshow pulse, single leave_n low, busy[1]=0.
- teller_open[2] drops while calling teller 2 -> call_valid=0, no leave_n pulse, state IDLE.
- p_count=0, eflag=1, all tellers free -> call_valid stays 0 for 100 cycles; p_count=7 -> wait_est=35.
- rst pulsed in the RELEASE cycle -> leave_n=1 and call_valid=0 the next cycle, busy=0, wait_est=0.
